// File: rtl/core_dma.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : core_dma
// Description : Prioritised multi-channel DMA that stalls the CPU and performs
//               block copies (read source, write fixed register) or single-byte
//               fetches on get/put-aligned bus cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module core_dma #(
    parameter int CHANNELS  = 2,
    parameter int LEN_WIDTH = 8
) (
    input  logic                          I_clock,
    input  logic                          I_reset,
    input  logic                          I_cycle,
    input  logic                          I_core_rdwr,
    input  logic [7:0]                    I_rd_data,
    input  logic [CHANNELS-1:0]           I_req,
    input  logic [CHANNELS-1:0]           I_mode,
    input  logic [16*CHANNELS-1:0]        I_src,
    input  logic [16*CHANNELS-1:0]        I_dst,
    input  logic [LEN_WIDTH*CHANNELS-1:0] I_len,
    output logic                          O_halt,
    output logic                          O_bus_en,
    output logic [15:0]                   O_addr,
    output logic [7:0]                    O_wr_data,
    output logic                          O_rdwr,
    output logic [7:0]                    O_fetch_data,
    output logic [CHANNELS-1:0]           O_ack,
    output logic                          O_busy
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_HALT  = 3'd2;
    localparam logic [2:0] S_DUMMY = 3'd3;
    localparam logic [2:0] S_ALIGN = 3'd4;
    localparam logic [2:0] S_READ  = 3'd5;
    localparam logic [2:0] S_WRITE = 3'd6;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [2:0]           w_align;
    logic                 r_parity;
    logic [IDX_W-1:0]     r_cur;
    logic [IDX_W-1:0]     w_cur_next;
    logic [CHANNELS-1:0]  r_pending;
    logic [CHANNELS-1:0]  r_active;
    logic [CHANNELS-1:0]  r_mode;
    logic [CHANNELS-1:0]  r_ack;
    logic [CHANNELS-1:0]  w_done;
    logic [15:0]          r_src [CHANNELS];
    logic [15:0]          r_dst [CHANNELS];
    logic [LEN_WIDTH-1:0] r_cnt [CHANNELS];
    logic [7:0]           r_data;
    logic [7:0]           r_fetch;
    logic                 w_load;
    logic                 w_finish;
    logic                 w_first_vld;
    logic                 w_other_vld;
    logic [IDX_W-1:0]     w_first_idx;
    logic [IDX_W-1:0]     w_other_idx;

    // Lowest-index pending channel, and the same excluding the channel in service.
    always_comb begin
        w_first_vld = 1'b0;
        w_first_idx = '0;
        w_other_vld = 1'b0;
        w_other_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_first_vld = 1'b1;
                w_first_idx = IDX_W'(i);
            end
            if (r_pending[i] && (IDX_W'(i) != r_cur)) begin
                w_other_vld = 1'b1;
                w_other_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_state  <= S_IDLE;
            r_parity <= 1'b0;
            r_cur    <= '0;
        end else if (I_cycle) begin
            r_state  <= w_state_next;
            r_parity <= ~r_parity;
            r_cur    <= w_cur_next;
        end
    end

    // A bus cycle must read on a get (parity 0) slot; w_align picks the next state
    // that lands the upcoming read there.
    always_comb begin
        w_state_next = r_state;
        w_cur_next   = r_cur;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        w_align      = r_parity ? S_READ : S_ALIGN;
        case (r_state)
            S_IDLE: begin
                if (w_first_vld) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (I_core_rdwr) begin
                    w_state_next = S_HALT;
                    w_cur_next   = w_first_idx;
                    w_load       = 1'b1;
                end
            end
            S_HALT:  w_state_next = r_mode[r_cur] ? S_DUMMY : w_align;
            S_DUMMY: w_state_next = w_align;
            S_ALIGN: w_state_next = S_READ;
            S_READ: begin
                if (r_mode[r_cur]) w_finish = 1'b1;
                else               w_state_next = S_WRITE;
            end
            S_WRITE: begin
                if (r_cnt[r_cur] == LEN_WIDTH'(1)) begin
                    w_finish = 1'b1;
                end else if (w_first_vld && (w_first_idx < r_cur)) begin
                    w_state_next = w_align;
                    w_cur_next   = w_first_idx;
                    w_load       = ~r_active[w_first_idx];
                end else begin
                    w_state_next = S_READ;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // Suspended channels resume from their saved src/count without reloading.
        if (w_finish) begin
            if (w_other_vld) begin
                w_state_next = w_align;
                w_cur_next   = w_other_idx;
                w_load       = ~r_active[w_other_idx];
            end else begin
                w_state_next = S_IDLE;
            end
        end
    end

    assign w_done = w_finish ? (CHANNELS'(1) << r_cur) : '0;

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_pending <= '0;
            r_active  <= '0;
            r_mode    <= '0;
            r_ack     <= '0;
            r_data    <= '0;
            r_fetch   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_src[i] <= '0;
                r_dst[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (I_cycle) begin
            r_pending <= (r_pending | I_req) & ~w_done;
            r_active  <= r_active & ~w_done;
            r_ack     <= w_done;
            if (r_state == S_READ) begin
                if (r_mode[r_cur]) r_fetch <= I_rd_data;
                else               r_data  <= I_rd_data;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_load && (w_cur_next == IDX_W'(i))) begin
                    r_src[i]    <= I_src[i*16 +: 16];
                    r_dst[i]    <= I_dst[i*16 +: 16];
                    r_cnt[i]    <= I_len[i*LEN_WIDTH +: LEN_WIDTH];
                    r_mode[i]   <= I_mode[i];
                    r_active[i] <= 1'b1;
                end else if ((r_state == S_WRITE) && (r_cur == IDX_W'(i))) begin
                    r_src[i] <= r_src[i] + 16'd1;
                    r_cnt[i] <= r_cnt[i] - LEN_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        O_halt    = (r_state != S_IDLE);
        O_bus_en  = 1'b0;
        O_addr    = '0;
        O_wr_data = '0;
        O_rdwr    = 1'b1;
        case (r_state)
            S_READ: begin
                O_bus_en = 1'b1;
                O_addr   = r_src[r_cur];
            end
            S_WRITE: begin
                O_bus_en  = 1'b1;
                O_rdwr    = 1'b0;
                O_addr    = r_dst[r_cur];
                O_wr_data = r_data;
            end
            default: ;
        endcase
    end

    assign O_fetch_data = r_fetch;
    assign O_ack        = r_ack;
    assign O_busy       = (|r_pending) || (r_state != S_IDLE);

endmodule
`default_nettype wire
